// File: rtl/mux_4x1_dataflow_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1_dataflow_if
// Description : Data/select bundle feeding the registered 4-to-1 word mux.
// Revision    : 1.0
// ============================================================================
interface mux_4x1_dataflow_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A0_i;
    logic [WIDTH-1:0] A1_i;
    logic [WIDTH-1:0] A2_i;
    logic [WIDTH-1:0] A3_i;
    logic             S0_i;
    logic             S1_i;
    logic [WIDTH-1:0] Y_o;

    modport master (
        output A0_i,
        output A1_i,
        output A2_i,
        output A3_i,
        output S0_i,
        output S1_i,
        input  Y_o
    );

    modport slave (
        input  A0_i,
        input  A1_i,
        input  A2_i,
        input  A3_i,
        input  S0_i,
        input  S1_i,
        output Y_o
    );
endinterface
`default_nettype wire

// File: rtl/mux_4x1_dataflow.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1_dataflow
// Description : Parameterised 4-to-1 word mux, AND-OR selection, registered Y.
// Revision    : 1.0
// ============================================================================
module mux_4x1_dataflow #(
    parameter int WIDTH = 4
) (
    input  wire                     clk_i,
    input  wire                     rst_i,
    mux_4x1_dataflow_if.slave       bus
);

    localparam logic [WIDTH-1:0] c_Y_RESET = '0;

    logic [3:0]       w_sel_dec;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    // One-hot decode of {S1,S0}; each term gates exactly one source word.
    assign w_sel_dec[0] = ~bus.S1_i & ~bus.S0_i;
    assign w_sel_dec[1] = ~bus.S1_i &  bus.S0_i;
    assign w_sel_dec[2] =  bus.S1_i & ~bus.S0_i;
    assign w_sel_dec[3] =  bus.S1_i &  bus.S0_i;

    assign y_d = ({WIDTH{w_sel_dec[0]}} & bus.A0_i)
               | ({WIDTH{w_sel_dec[1]}} & bus.A1_i)
               | ({WIDTH{w_sel_dec[2]}} & bus.A2_i)
               | ({WIDTH{w_sel_dec[3]}} & bus.A3_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_q <= c_Y_RESET;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.Y_o = y_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_4x1_dataflow.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4x1_dataflow
// Description : Directed + random bench for mux_4x1_dataflow at WIDTH 4/1/16.
// Revision    : 1.0
// ============================================================================
module tb_mux_4x1_dataflow;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a [4];
    logic        s0 = 1'b0;
    logic        s1 = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q = '0;
    logic        model_valid = 1'b0;

    always #5 clk = ~clk;

    mux_4x1_dataflow_if #(.WIDTH(4))  if4  ();
    mux_4x1_dataflow_if #(.WIDTH(1))  if1  ();
    mux_4x1_dataflow_if #(.WIDTH(16)) if16 ();

    assign if4.A0_i  = a[0][3:0];
    assign if4.A1_i  = a[1][3:0];
    assign if4.A2_i  = a[2][3:0];
    assign if4.A3_i  = a[3][3:0];
    assign if4.S0_i  = s0;
    assign if4.S1_i  = s1;
    assign if1.A0_i  = a[0][0:0];
    assign if1.A1_i  = a[1][0:0];
    assign if1.A2_i  = a[2][0:0];
    assign if1.A3_i  = a[3][0:0];
    assign if1.S0_i  = s0;
    assign if1.S1_i  = s1;
    assign if16.A0_i = a[0];
    assign if16.A1_i = a[1];
    assign if16.A2_i = a[2];
    assign if16.A3_i = a[3];
    assign if16.S0_i = s0;
    assign if16.S1_i = s1;

    mux_4x1_dataflow #(.WIDTH(4))  u_dut4  (.clk_i(clk), .rst_i(rst), .bus(if4));
    mux_4x1_dataflow #(.WIDTH(1))  u_dut1  (.clk_i(clk), .rst_i(rst), .bus(if1));
    mux_4x1_dataflow #(.WIDTH(16)) u_dut16 (.clk_i(clk), .rst_i(rst), .bus(if16));

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the word chosen by the select code, seen one edge later.
    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (rst) exp_q <= '0;
        else     exp_q <= a[{s1, s0}];
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_w4",  {12'h0, if4.Y_o},  {12'h0, exp_q[3:0]});
            check("model_w1",  {15'h0, if1.Y_o},  {15'h0, exp_q[0]});
            check("model_w16", if16.Y_o, exp_q);
        end
    end

    // At a falling edge: check the result of the previous vector, then drive the next.
    task automatic cyc(input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [15:0] a3,
                       input logic ss1, input logic ss0, input logic r,
                       input bit chk, input logic [15:0] lit, input string nm);
        @(negedge clk);
        if (chk) begin
            check({nm, "_dut"},   {12'h0, if4.Y_o},    lit);
            check({nm, "_model"}, {12'h0, exp_q[3:0]}, lit);
        end
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        s1 = ss1; s0 = ss0; rst = r;
    endtask

    initial begin
        a[0] = '0; a[1] = '0; a[2] = '0; a[3] = '0;

        cyc(16'hF, 16'hF, 16'hF, 16'hF, 1, 1, 1, 0, 16'h0, "init");
        cyc(16'hF, 16'hF, 16'hF, 16'hF, 1, 1, 1, 1, 16'h0, "rst_hold1");
        cyc(16'hF, 16'hF, 16'hF, 16'hF, 1, 1, 0, 1, 16'h0, "rst_hold2");
        cyc(16'h1, 16'h2, 16'h4, 16'h8, 0, 0, 0, 1, 16'hF, "rst_release");
        cyc(16'h1, 16'h2, 16'h4, 16'h8, 0, 1, 0, 1, 16'h1, "sel00");
        cyc(16'h1, 16'h2, 16'h4, 16'h8, 1, 0, 0, 1, 16'h2, "sel01");
        cyc(16'h1, 16'h2, 16'h4, 16'h8, 1, 1, 0, 1, 16'h4, "sel10");
        cyc(16'h0, 16'h5, 16'hA, 16'h0, 0, 1, 0, 1, 16'h8, "sel11");
        cyc(16'h0, 16'h5, 16'hA, 16'h0, 1, 0, 0, 1, 16'h5, "s0_only");
        for (int i = 0; i < 16; i++) begin
            cyc(16'h0, 16'h0, 16'(i), 16'h0, 1, 0, 0, 1,
                (i == 0) ? 16'hA : 16'(i - 1), (i == 0) ? "s1_only" : "pass");
        end
        cyc(16'h0, 16'h0, 16'h0, 16'hC, 1, 1, 0, 1, 16'hF, "pass15");
        cyc(16'h0, 16'h0, 16'h0, 16'hC, 1, 1, 0, 1, 16'hC, "stream");
        cyc(16'h0, 16'h0, 16'h0, 16'hC, 1, 1, 1, 1, 16'hC, "stream2");
        #1 check("rst_between_edges", {12'h0, if4.Y_o}, 16'hC);
        cyc(16'h0, 16'h0, 16'h0, 16'hC, 1, 1, 0, 1, 16'h0, "midrst");
        cyc(16'h0, 16'h0, 16'h0, 16'hC, 1, 1, 0, 1, 16'hC, "resume");

        for (int i = 0; i < 20; i++) begin
            cyc(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom), 0, 0, 16'h0, "rand");
        end
        cyc(16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, "flush");
        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_4x1_dataflow.md
# mux_4x1_dataflow

Parameterised 4-to-1 word multiplexer with a registered output. It selects one of four WIDTH-bit data words using two independent select bits and presents the chosen word on Y_o one clock after sampling. It is a leaf datapath primitive in the combinational-circuit library, used wherever a clocked, glitch-free selected word is needed downstream.

## Interface
Parameters:
- WIDTH, default 4, bit width of each data input and of the output; legal range ≥ 1.

Ports:
- clk_i, input, 1, the single clock; all state updates on its rising edge.
- rst_i, input, 1, reset; synchronous and active-high.
- A0_i, input, WIDTH, data word 0.
- A1_i, input, WIDTH, data word 1.
- A2_i, input, WIDTH, data word 2.
- A3_i, input, WIDTH, data word 3.
- S0_i, input, 1, select bit 0 (LSB of the select code).
- S1_i, input, 1, select bit 1 (MSB of the select code).
- Y_o, output, WIDTH, registered selected word.

## Operation
- Select code sel = {S1_i, S0_i}.
- Selection, written as S1_i S0_i -> source:
  - 00 -> A0_i
  - 01 -> A1_i
  - 10 -> A2_i
  - 11 -> A3_i
- Selection is a pure dataflow (continuous-assign style) expression feeding the output register. Its next-state value is a bitwise AND-OR of the four words gated by fully decoded select terms, or an equivalent conditional operator tree.
- Data words pass through unmodified:
  - no sign extension, truncation or arithmetic;
  - all WIDTH bits are copied bit-for-bit.
- There is no enable; the register loads the selected word on every clock edge when not in reset.

## Timing
- Rising-edge clk_i:
  - if rst_i = 1, Y_o <= 0 (all WIDTH bits);
  - else Y_o <= selected word.
- Reset value of Y_o is 0. The reset is synchronous: asserting rst_i between edges does not change Y_o until the next rising edge.
- Latency is exactly 1 cycle from inputs and selects to Y_o. Y_o is stable for the full cycle and never glitches on input changes.
- Reset has priority over any select or data activity on the same edge.
- Deasserting rst_i: the first non-reset edge loads the currently selected word. There are no extra pipeline bubbles.
- Reset mid-stream: the word selected at that edge is discarded and Y_o = 0. Loading resumes on the next edge after rst_i falls.
- Simultaneous change of S1_i, S0_i and data before an edge: only values at the edge matter. Y_o reflects the new select applied to the new data.
- Select lines changing between edges have no effect on Y_o until the next edge.
- Throughput: one new selection per cycle. Back-to-back select changes each appear one cycle later, in order.

## Test plan
- Reset: hold rst_i = 1 with A0..A3 = 4'hF, sel = 11 for 2 edges -> Y_o = 4'h0. Release rst_i -> next edge Y_o = 4'hF.
- Exhaustive select: A0 = 1, A1 = 2, A2 = 4, A3 = 8. Step S1_i S0_i through 00, 01, 10, 11, one per cycle -> Y_o = 1, 2, 4, 8, each one cycle after the corresponding select.
- Select-bit ordering: S0_i = 1, S1_i = 0 with A1 = 4'h5, A2 = 4'hA -> Y_o = 4'h5. Swap to S0_i = 0, S1_i = 1 -> Y_o = 4'hA.
- Data passthrough: sel = 10, A2_i driven 0..15 over 16 cycles with other words = 4'h0 -> Y_o tracks A2_i with one cycle delay, all 16 values intact.
- Mid-stream reset: streaming sel = 11, A3 = 4'hC; pulse rst_i for 1 cycle -> that edge Y_o = 0, next edge Y_o = 4'hC.
- Random regression: 20 cycles of random {A0..A3} and random selects vs. a one-cycle-delayed reference model -> zero mismatches. Repeat at WIDTH = 1 and WIDTH = 16.
